// File: rtl/trivium_pkg.sv
// trivium_pkg
//   Shared definitions for the trivium keystream subsystem.
//   - trivium_state_e : sequencer states used by trivium_ctrl
//   - TRIVIUM_WARMUP  : core steps discarded after a load (4 x 288)
//   - TRIVIUM_CNT_W   : width of the warm-up counter (must hold WARMUP-1)
//   - TRIVIUM_KEY/IV  : default key and IV, shared with the trivium core
package trivium_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WARM = 2'd2,
        GEN  = 2'd3
    } trivium_state_e;

    localparam int TRIVIUM_WARMUP = 1152;
    localparam int TRIVIUM_CNT_W  = 11;

    localparam logic [79:0] TRIVIUM_KEY = 80'h9719CFC92A9FF688F9AA;
    localparam logic [79:0] TRIVIUM_IV  = 80'hECBB76B09AFF71D0D151;

endpackage

// File: rtl/trivium_ctrl.sv
// trivium_ctrl
//   Sequencer for the trivium keystream core. After a start request it pulses
//   core_load once, steps the core WARMUP times while discarding its output,
//   then steps it continuously, packing keystream bits LSB-first into bytes
//   that are offered on a valid/ready stream.
//
// Ports
//   clk          in   1  clock, all state updates on posedge
//   rst          in   1  asynchronous reset, active low
//   enable       in   1  global run gate; low freezes everything
//   start        in   1  request (re)initialisation of the core
//   core_load    out  1  one-cycle pulse: core loads key/IV
//   core_step    out  1  core advances one bit this cycle
//   core_ks_bit  in   1  keystream bit of the core's current state
//   init_done    out  1  high while generating (warm-up complete)
//   ks_valid     out  1  ks_data holds an unconsumed byte
//   ks_ready     in   1  consumer accepts byte when ks_valid & ks_ready
//   ks_data      out  8  keystream byte, first generated bit in bit 0
module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int WARMUP = TRIVIUM_WARMUP,
    parameter int CNT_W  = TRIVIUM_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       start,
    output logic       core_load,
    output logic       core_step,
    input  logic       core_ks_bit,
    output logic       init_done,
    output logic       ks_valid,
    input  logic       ks_ready,
    output logic [7:0] ks_data
);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);

    trivium_state_e   state;
    trivium_state_e   state_next;
    logic [CNT_W-1:0] wcnt;
    logic [2:0]       bcnt;
    logic [6:0]       acc;
    logic             stall;

    // The last bit of a byte may only be taken when the output register can
    // accept it; otherwise the core is held so no keystream bit is lost.
    assign stall = (bcnt == 3'd7) && ks_valid && !ks_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; nothing moves while enable is low, and start is only
    // honoured from IDLE or GEN.
    always_comb begin
        state_next = state;
        if (enable) begin
            case (state)
                IDLE:    if (start) state_next = LOAD;
                LOAD:    state_next = WARM;
                WARM:    if (wcnt == WARM_LAST) state_next = GEN;
                GEN:     if (start) state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Core control outputs, all gated by enable so a frozen controller never
    // moves the core.
    always_comb begin
        core_load = 1'b0;
        core_step = 1'b0;
        init_done = 1'b0;
        case (state)
            LOAD: core_load = enable;
            WARM: core_step = enable;
            GEN: begin
                init_done = 1'b1;
                core_step = enable && !stall;
            end
            default: ;
        endcase
    end

    // Warm-up counter, bit packer and output register.
    // The packer shifts in from the top, so after seven steps acc[0] holds the
    // first bit of the byte and the eighth bit is appended directly as bit 7.
    // A completed byte overwrites the output register even if the previous one
    // is being taken in the same cycle, keeping ks_valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt     <= '0;
            bcnt     <= '0;
            acc      <= '0;
            ks_valid <= 1'b0;
            ks_data  <= '0;
        end else if (enable) begin
            case (state)
                LOAD: begin
                    wcnt <= '0;
                    bcnt <= '0;
                    acc  <= '0;
                end
                WARM: begin
                    wcnt <= wcnt + 1'b1;
                end
                GEN: begin
                    if (start) begin
                        bcnt     <= '0;
                        acc      <= '0;
                        ks_valid <= 1'b0;
                    end else if (core_step) begin
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            ks_data  <= {core_ks_bit, acc};
                            ks_valid <= 1'b1;
                        end else begin
                            acc <= {core_ks_bit, acc[6:1]};
                            if (ks_valid && ks_ready) begin
                                ks_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
